// File: rtl/fe_branch_predictor.sv
// Fetch-side branch predictor: gshare pattern table of 2-bit counters indexed
// by (PC ^ global history), plus a direct-mapped BTB holding tag and target.
// Lookup is combinational from fetch_pc. Updates arrive from AGEX carrying the
// table indices that were produced at prediction time.
// After reset an INIT sequence walks every PT entry (and the BTB valid bits)
// before predictions are enabled. init_busy is the FSM state made visible.
//
// Update handshake: upd_valid is a single-cycle strobe with no back-pressure.
// Every strobe seen while READY is consumed at that clock edge; strobes seen
// during INIT are dropped without effect.
module fe_branch_predictor #(
    parameter int DBITS        = 32,
    parameter int BHRBITS      = 8,
    parameter int PTINDEXBITS  = 8,
    parameter int BTBINDEXBITS = 4,
    parameter int TAGBITS      = 26
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [DBITS-1:0]        fetch_pc,
    output logic                    pred_btb_hit,
    output logic                    pred_taken,
    output logic [DBITS-1:0]        pred_next_pc,
    output logic [PTINDEXBITS-1:0]  pred_pt_index,
    output logic [BTBINDEXBITS-1:0] pred_btb_index,
    output logic                    init_busy,
    input  logic                    upd_valid,
    input  logic [DBITS-1:0]        upd_pc,
    input  logic                    upd_taken,
    input  logic [DBITS-1:0]        upd_target,
    input  logic [PTINDEXBITS-1:0]  upd_pt_index,
    input  logic [BTBINDEXBITS-1:0] upd_btb_index,
    output logic [BHRBITS-1:0]      bhr_out
);

    localparam int PT_ENTRIES  = 1 << PTINDEXBITS;
    localparam int BTB_ENTRIES = 1 << BTBINDEXBITS;

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_t;

    state_t                   r_state;
    state_t                   w_state_next;
    logic [PTINDEXBITS-1:0]   r_ptr;
    logic [PTINDEXBITS-1:0]   w_ptr_next;
    logic [BHRBITS-1:0]       r_bhr;
    logic [BHRBITS-1:0]       w_bhr_next;
    logic                     w_init_we;
    logic                     w_upd_we;

    // Storage arrays: contents are only ever initialised by the INIT walk.
    logic [1:0]               r_pt         [PT_ENTRIES];
    logic [BTB_ENTRIES-1:0]   r_btb_valid;
    logic [TAGBITS-1:0]       r_btb_tag    [BTB_ENTRIES];
    logic [DBITS-1:0]         r_btb_target [BTB_ENTRIES];

    logic                     w_ready;
    logic [PTINDEXBITS-1:0]   w_pt_index;
    logic [BTBINDEXBITS-1:0]  w_btb_index;
    logic [TAGBITS-1:0]       w_fetch_tag;
    logic                     w_btb_hit;
    logic                     w_taken;
    logic [DBITS-1:0]         w_seq_pc;
    logic                     w_init_clr_btb;
    logic [1:0]               w_pt_old;
    logic [1:0]               w_pt_upd;
    logic                     w_unused_bits;

    // PC bits below the BTB tag are implied by the returned BTB index.
    assign w_unused_bits = ^{upd_pc[DBITS-TAGBITS-1:0], fetch_pc[1:0]};

    // Lookup path: pure function of fetch_pc and pre-edge table state (no bypass).
    assign w_ready      = (r_state == ST_READY);
    assign w_pt_index   = fetch_pc[PTINDEXBITS+1:2] ^ r_bhr;
    assign w_btb_index  = fetch_pc[BTBINDEXBITS+1:2];
    assign w_fetch_tag  = fetch_pc[DBITS-1:DBITS-TAGBITS];
    assign w_btb_hit    = w_ready & r_btb_valid[w_btb_index] &
                          (r_btb_tag[w_btb_index] == w_fetch_tag);
    assign w_taken      = w_btb_hit & r_pt[w_pt_index][1];
    assign w_seq_pc     = fetch_pc + DBITS'(4);

    assign pred_btb_hit   = w_btb_hit;
    assign pred_taken     = w_taken;
    assign pred_next_pc   = w_taken ? r_btb_target[w_btb_index] : w_seq_pc;
    assign pred_pt_index  = w_pt_index;
    assign pred_btb_index = w_btb_index;
    assign init_busy      = (r_state == ST_INIT);
    assign bhr_out        = r_bhr;

    // Only the first BTB_ENTRIES steps of the INIT walk touch the BTB.
    assign w_init_clr_btb = (r_ptr[PTINDEXBITS-1:BTBINDEXBITS] == '0);

    // Saturating 2-bit counter step for the entry named by the pipeline.
    assign w_pt_old = r_pt[upd_pt_index];
    always_comb begin
        w_pt_upd = w_pt_old;
        if (upd_taken) begin
            if (w_pt_old != 2'b11) w_pt_upd = w_pt_old + 2'd1;
        end else begin
            if (w_pt_old != 2'b00) w_pt_upd = w_pt_old - 2'd1;
        end
    end

    // Next-state logic: INIT walks the pointer once, READY absorbs updates.
    always_comb begin
        w_state_next = r_state;
        w_ptr_next   = r_ptr;
        w_bhr_next   = r_bhr;
        w_init_we    = 1'b0;
        w_upd_we     = 1'b0;
        case (r_state)
            ST_INIT: begin
                w_init_we  = 1'b1;
                w_ptr_next = r_ptr + PTINDEXBITS'(1);
                if (r_ptr == '1) w_state_next = ST_READY;
            end
            ST_READY: begin
                if (upd_valid) begin
                    w_upd_we   = 1'b1;
                    w_bhr_next = {r_bhr[BHRBITS-2:0], upd_taken};
                end
            end
            default: begin
                w_state_next = ST_INIT;
            end
        endcase
    end

    // State, clear pointer and global history registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_INIT;
            r_ptr   <= '0;
            r_bhr   <= '0;
        end else begin
            r_state <= w_state_next;
            r_ptr   <= w_ptr_next;
            r_bhr   <= w_bhr_next;
        end
    end

    // Table writes: INIT clears entries, READY applies resolved-branch updates.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (w_init_we) begin
                r_pt[r_ptr] <= 2'b01;
                if (w_init_clr_btb) r_btb_valid[r_ptr[BTBINDEXBITS-1:0]] <= 1'b0;
            end else if (w_upd_we) begin
                r_pt[upd_pt_index] <= w_pt_upd;
                if (upd_taken) begin
                    r_btb_valid[upd_btb_index]  <= 1'b1;
                    r_btb_tag[upd_btb_index]    <= upd_pc[DBITS-1:DBITS-TAGBITS];
                    r_btb_target[upd_btb_index] <= upd_target;
                end
            end
        end
    end

endmodule
